// File: rtl/ram_arbiter_if.sv
// Requester and memory-side signal bundle for ram_arbiter.
// master: CPU front end plus memory; slave: the arbiter itself.
interface ram_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          req1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          err;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic          mem_response;
    logic [DW-1:0] mem_out;

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output mem_response, mem_out,
        input  ack0, ack1, rdata, busy, err, mem_data, mem_addr, mem_wr
    );

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  mem_response, mem_out,
        output ack0, ack1, rdata, busy, err, mem_data, mem_addr, mem_wr
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-ported word memory.
// Define RAM_ARB_TIMEOUT_EN to build the WAIT-state timeout counter and sticky err flag.
module ram_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pick1;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign pick1 = bus.req1 && (!bus.req0 || !last_q);

`ifdef RAM_ARB_TIMEOUT_EN
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
`ifdef RAM_ARB_TIMEOUT_EN
        err_d      = err_q;
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    win_d      = pick1;
                    mem_wr_d   = pick1 ? bus.wr1    : bus.wr0;
                    mem_addr_d = pick1 ? bus.addr1  : bus.addr0;
                    mem_data_d = pick1 ? bus.wdata1 : bus.wdata0;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = StGuard;
            StGuard: begin
                // mem_response may still reflect the previous access here.
`ifdef RAM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (bus.mem_response) begin
                    if (!mem_wr_q) begin
                        rdata_d = bus.mem_out;
                    end
                    state_d = StDone;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            StDone: begin
                last_d  = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.ack0     = (state_q == StDone) && !win_q;
    assign bus.ack1     = (state_q == StDone) &&  win_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.rdata    = rdata_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
`ifdef RAM_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a falling-edge memory model.
// Timeout vectors run only when RAM_ARB_TIMEOUT_EN is defined.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(32), .DW(32)) bus ();

    ram_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory: a changed access drops the response for one falling edge, then raises it.
    logic [31:0] mem [0:255];
    logic        last_wr;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic        pend;
    logic        noresp = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mem[8'h10]       = 32'hDEADBEEF;
            last_wr          = 1'b0;
            last_addr        = '0;
            last_data        = '0;
            pend             = 1'b0;
            bus.mem_response = 1'b0;
            bus.mem_out      = '0;
        end else if (bus.mem_wr !== last_wr || bus.mem_addr !== last_addr
                     || bus.mem_data !== last_data) begin
            last_wr   = bus.mem_wr;
            last_addr = bus.mem_addr;
            last_data = bus.mem_data;
            if (bus.mem_wr) mem[bus.mem_addr[7:0]] = bus.mem_data;
            bus.mem_out      = mem[bus.mem_addr[7:0]];
            bus.mem_response = 1'b0;
            pend             = 1'b1;
        end else if (pend) begin
            bus.mem_response = !noresp;
            pend             = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    logic saw_wr;
    logic wrong_ack;

    // Issue one request and return the number of sampled cycles until its ack (50 = none).
    task automatic do_access(input int port, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int lat);
        logic got;
        @(posedge clk);
        #1;
        if (port == 0) begin
            bus.req0 = 1'b1; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = data;
        end else begin
            bus.req1 = 1'b1; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = data;
        end
        saw_wr    = 1'b0;
        wrong_ack = 1'b0;
        got       = 1'b0;
        lat       = 0;
        while (!got && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_wr) saw_wr = 1'b1;
            if ((port == 0) ? bus.ack0 : bus.ack1) got = 1'b1;
            if ((port == 0) ? bus.ack1 : bus.ack0) wrong_ack = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    int lat;
    int order [4];
    int ack_cyc [4];
    int nack;
    logic dual;

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_ack0", {31'b0, bus.ack0}, 0);
        check("rst_ack1", {31'b0, bus.ack1}, 0);
        check("rst_err", {31'b0, bus.err}, 0);
        check("rst_mem_wr", {31'b0, bus.mem_wr}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data", bus.mem_data, 0);
        check("rst_rdata", bus.rdata, 0);

        do_access(0, 1'b0, 32'h10, 32'h0, lat);
        check("rd0_lat", lat, 4);
        check("rd0_rdata", bus.rdata, 32'hDEADBEEF);
        check("rd0_mem_wr", {31'b0, saw_wr}, 0);
        check("rd0_other_ack", {31'b0, wrong_ack}, 0);

        do_access(1, 1'b1, 32'h20, 32'h55AA, lat);
        check("wr1_lat", lat, 4);
        check("wr1_rdata_held", bus.rdata, 32'hDEADBEEF);
        check("wr1_mem", mem[8'h20], 32'h55AA);
        check("wr1_other_ack", {31'b0, wrong_ack}, 0);
        do_access(0, 1'b0, 32'h20, 32'h0, lat);
        check("rd20_lat", lat, 4);
        check("rd20_rdata", bus.rdata, 32'h55AA);

        do_access(0, 1'b1, 32'h4, 32'h7, lat);
        check("same_wr1_lat", lat, 4);
        do_access(0, 1'b1, 32'h4, 32'h7, lat);
        check("same_wr2_lat", lat, 4);
        check("same_wr_mem", mem[8'h4], 32'h7);

        // Both ports held high from reset: expect 0,1,0,1 spaced 5 cycles apart.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'h10;
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 32'h20;
        nack = 0;
        dual = 1'b0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.ack0 && bus.ack1) dual = 1'b1;
            if (bus.ack0 || bus.ack1) begin
                order[nack]   = bus.ack1 ? 1 : 0;
                ack_cyc[nack] = c;
                check("tie_rdata", bus.rdata, bus.ack1 ? 32'h55AA : 32'hDEADBEEF);
                nack++;
            end
        end
        bus.req0 = 0;
        bus.req1 = 0;
        check("tie_count", nack, 4);
        check("tie_dual", {31'b0, dual}, 0);
        for (int i = 0; i < nack; i++) begin
            check("tie_order", order[i], i % 2);
            if (i > 0) check("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 5);
        end

        // Reset while the write sits in GUARD.
        @(posedge clk);
        #1;
        bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 32'h30; bus.wdata1 = 32'h99;
        @(posedge clk);
        #1;
        check("guard_busy", {31'b0, bus.busy}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req1 = 0;
        check("rstmid_busy", {31'b0, bus.busy}, 0);
        check("rstmid_ack", {30'b0, bus.ack1, bus.ack0}, 0);
        @(posedge clk);
        #1;
        check("rstmid_ack_next", {30'b0, bus.ack1, bus.ack0}, 0);
        do_access(1, 1'b0, 32'h20, 32'h0, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_rdata", bus.rdata, 32'h55AA);

`ifdef RAM_ARB_TIMEOUT_EN
        noresp = 1'b1;
        do_access(0, 1'b0, 32'h10, 32'h0, lat);
        check("to_lat", lat, 11);
        check("to_err", {31'b0, bus.err}, 1);
        check("to_rdata_held", bus.rdata, 32'h55AA);
        repeat (3) @(posedge clk);
        #1;
        check("to_err_sticky", {31'b0, bus.err}, 1);
        noresp = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("to_err_cleared", {31'b0, bus.err}, 0);
`else
        check("err_tied", {31'b0, bus.err}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer that shares the single-ported word memory between the instruction-fetch port (port 0) and the load/store port (port 1). It accepts one request at a time and drives the memory's data/addr/wr inputs. It completes each access by tracking the memory's response flag, then returns read data and a one-cycle acknowledge to the winning requester. It sits between the CPU front end and the memory, and is the only block allowed to drive memory inputs.

## Interface
- `AW`, 32, address width (memory address bus)
- `DW`, 32, data width
- `TIMEOUT`, 64, max cycles in WAIT before abort (only with `RAM_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock; block logic on rising edge; memory acts on falling edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `req0`, `req1`  in  1  request from port 0 / port 1
- `wr0`, `wr1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  access address
- `wdata0`, `wdata1`  in  DW  write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata`  out  DW  read data, valid in the `ack` cycle of a read
- `busy`  out  1  1 while not IDLE
- `err`  out  1  sticky timeout flag (tied 0 without macro)
- `mem_data`  out  DW  to memory data
- `mem_addr`  out  AW  to memory addr
- `mem_wr`  out  1  to memory wr
- `mem_response`  in  1  memory done flag
- `mem_out`  in  DW  memory read data

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE: if any `reqN` is high, pick a winner.
  - Only one requests: it wins.
  - Both request: the port not served last wins.
  - Latch the winner's wr/addr/wdata into `mem_*` and go to ISSUE.
- ISSUE: hold `mem_*`. Go to GUARD.
- GUARD: ignore `mem_response`, which may be stale from the previous access. Go to WAIT.
- WAIT: when `mem_response`=1, capture `mem_out` into `rdata` if it is a read. Go to DONE.
- DONE: pulse the winner's `ackN` for one cycle. Update the last-served pointer. Go to IDLE.
- `mem_*` holds its last values in IDLE. It is never changed outside an IDLE→ISSUE transition.
- Requester rules:
  - Hold `reqN` and payload stable until `ackN`.
  - `reqN` still high in the cycle after `ackN` counts as a new request.
- A write to the same address with the same data as the previous access is legal. The memory re-performs it harmlessly.

## Timing
- Reset values:
  - `ack0`/`ack1`/`busy`/`err`/`mem_wr` = 0.
  - `mem_addr`/`mem_data`/`rdata` = 0.
  - State = IDLE.
  - Last-served pointer = port 1, so port 0 wins the first tie.
- Minimum latency: request sampled at edge k → `ackN` high during cycle k+4, with WAIT lasting 1 cycle.
  - A changed access completes in WAIT at edge k+3 at the earliest.
- Back-to-back from a single port: the next request is sampled in the IDLE cycle after DONE. Throughput is at most one access per 5 cycles.
- Simultaneous requests: strict alternation while both stay asserted.
- `rst` mid-operation:
  - Returns to IDLE at that edge, drops `busy`, issues no `ack`, clears `err`.
  - An in-flight write may or may not have committed.
- `rdata` holds its value until the next read completes. It does not change on write completion.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - After `TIMEOUT` cycles without `mem_response`, go to DONE, pulse `ackN`, and set `err` (sticky until `rst`).
  - `rdata` is left unchanged on abort.
- Not defined:
  - No counter is built, `err` is tied 0, and WAIT waits indefinitely.

## Test plan
- Reset, then `req0` read at 0x10 holding 0xDEADBEEF → `ack0` in cycle k+4 with `rdata`=0xDEADBEEF; `mem_wr`=0 throughout.
- `req1` write 0x55AA to 0x20, then `req0` read 0x20 → `ack1`, then `ack0` with `rdata`=0x55AA.
- `req0` and `req1` held high together from reset, over four accesses → acks in order 0,1,0,1; never two acks in one cycle.
- Same write, 0x7 to 0x4, issued twice → both acked; the second ack within 4 cycles; memory word 0x4 = 0x7.
- `rst` asserted in GUARD → next cycle IDLE, `busy`=0, no ack; a subsequent `req1` is served normally.
- With `RAM_ARB_TIMEOUT_EN`, `TIMEOUT`=8, `mem_response` forced 0 → `ack0` after 8 WAIT cycles, `err`=1 and stays 1 until `rst`.
